// File: rtl/mesh_2x4_noc.sv
// 2x4 mesh NoC: eight traffic-generator PEs, each on a 5-port XY router, single-flit packets.
// Optional MESH_ROUTE_ERR_EN adds pe_route_error_flag (sticky misdelivery report per PE).
package mesh_pkg;
    typedef struct packed {
        logic       valid;
        logic [2:0] src;
        logic [2:0] dst;
        logic [2:0] seq;
    } flit_t;
endpackage

// Port order everywhere: 0=L, 1=N, 2=S, 3=E, 4=W.
module mesh_router import mesh_pkg::*; #(
    parameter int ID = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  flit_t [4:0] in_flit,
    output logic  [4:0] in_ready,
    output flit_t [4:0] out_flit,
    input  logic  [4:0] out_ready
);
    localparam logic [2:0] MY = 3'(ID);

    function automatic logic [2:0] xy_port(input logic [2:0] dst);
        if (dst[1:0] > MY[1:0])      return 3'd3;
        else if (dst[1:0] < MY[1:0]) return 3'd4;
        else if (dst[2] > MY[2])     return 3'd2;
        else if (dst[2] < MY[2])     return 3'd1;
        else                         return 3'd0;
    endfunction

    // {hit, index}: first requester at or after ptr, wrapping modulo 5
    function automatic logic [3:0] rr_pick(input logic [4:0] req, input logic [2:0] ptr);
        logic [3:0] r;
        int         idx;
        r = '0;
        for (int k = 4; k >= 0; k--) begin
            idx = (int'(ptr) + k) % 5;
            if (req[idx]) r = {1'b1, 3'(idx)};
        end
        return r;
    endfunction

    flit_t [4:0]      buf_q;
    logic  [4:0][2:0] rr_q;
    logic  [4:0][2:0] route;
    logic  [4:0][4:0] req;
    logic  [4:0][3:0] pick;
    logic  [4:0]      fwd;

    // Requests are masked by downstream emptiness, so a grant always moves the flit.
    always_comb begin
        route    = '0;
        req      = '0;
        pick     = '0;
        fwd      = '0;
        out_flit = '0;
        for (int i = 0; i < 5; i++) route[i] = xy_port(buf_q[i].dst);
        for (int o = 0; o < 5; o++) begin
            for (int i = 0; i < 5; i++)
                req[o][i] = buf_q[i].valid && (route[i] == 3'(o)) && out_ready[o];
            pick[o] = rr_pick(req[o], rr_q[o]);
            if (pick[o][3]) begin
                out_flit[o]         = buf_q[pick[o][2:0]];
                fwd[pick[o][2:0]]   = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < 5; i++) begin : g_rdy
        assign in_ready[i] = ~buf_q[i].valid;
    end

    // rst_n is active-high here despite its name
    always_ff @(posedge clk) begin
        if (rst_n) begin
            buf_q <= '0;
            rr_q  <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (fwd[i])
                    buf_q[i] <= '0;
                else if (!buf_q[i].valid && in_flit[i].valid)
                    buf_q[i] <= in_flit[i];
            end
            for (int o = 0; o < 5; o++)
                if (pick[o][3])
                    rr_q[o] <= (pick[o][2:0] == 3'd4) ? 3'd0 : pick[o][2:0] + 3'd1;
        end
    end
endmodule

module mesh_pe import mesh_pkg::*; #(
    parameter int ID = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        dbg_mode,
    input  logic        flush,
    input  logic [2:0]  send_num,
    input  logic [2:0]  recv_num,
    input  logic [3:0]  rate,
    input  logic [3:0]  mode,
    input  logic [23:0] dst_seq,
    output flit_t       inj_flit,
    input  logic        inj_ready,
    input  flit_t       ej_flit,
    output logic        send_flag,
    output logic        recv_flag
`ifdef MESH_ROUTE_ERR_EN
    ,
    output logic        route_err
`endif
);
    localparam logic [2:0] MY = 3'(ID);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t     state;
    logic [2:0] k, cnt, cnt_nxt, dst;
    logic [3:0] gap;
    logic       accept, hit;

    always_comb begin
        dst            = (mode == 4'd0) ? MY + 3'd1 + k : dst_seq[int'(k)*3 +: 3];
        inj_flit       = '0;
        inj_flit.valid = (state == SEND) && enable && !flush;
        inj_flit.src   = MY;
        inj_flit.dst   = dst;
        inj_flit.seq   = k;
        accept         = inj_flit.valid && inj_ready;
        hit            = ej_flit.valid && (!dbg_mode || ej_flit.dst == MY);
        cnt_nxt        = (hit && cnt != 3'd7) ? cnt + 3'd1 : cnt;
    end

    always_ff @(posedge clk) begin
        if (rst_n || flush) begin
            state     <= IDLE;
            k         <= '0;
            cnt       <= '0;
            gap       <= '0;
            send_flag <= 1'b0;
            recv_flag <= 1'b0;
`ifdef MESH_ROUTE_ERR_EN
            route_err <= 1'b0;
`endif
        end else begin
            cnt <= cnt_nxt;
            if (enable && cnt_nxt == recv_num) recv_flag <= 1'b1;
`ifdef MESH_ROUTE_ERR_EN
            if (ej_flit.valid && ej_flit.dst != MY) route_err <= 1'b1;
`endif
            case (state)
                IDLE: if (enable) begin
                    if (send_num == 3'd0) begin
                        state     <= DONE;
                        send_flag <= 1'b1;
                    end else begin
                        state <= SEND;
                    end
                end
                SEND: if (accept) begin
                    k <= k + 3'd1;
                    if (k + 3'd1 == send_num) begin
                        state     <= DONE;
                        send_flag <= 1'b1;
                    end else if (rate != 4'd0) begin
                        state <= GAP;
                        gap   <= rate;
                    end
                end
                GAP: if (enable) begin
                    if (gap <= 4'd1) state <= SEND;
                    gap <= gap - 4'd1;
                end
                DONE: ;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

module mesh_2x4_noc import mesh_pkg::*; #(
    parameter int NODES = 8,
    parameter int IDW   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NODES-1:0]     pe_enable,
    input  logic [NODES-1:0]     pe_dbg_mode_wire,
    input  logic [NODES*IDW-1:0] pe_send_num_wire,
    input  logic [NODES*IDW-1:0] pe_receive_num_wire,
    input  logic [NODES*4-1:0]   pe_rate_wire,
    input  logic [NODES*24-1:0]  pe_dst_seq_wire,
    input  logic [NODES*4-1:0]   pe_mode_wire,
    input  logic [NODES-1:0]     pe_flush_wire,
    output logic [NODES-1:0]     pe_task_receive_finish_flag,
    output logic [NODES-1:0]     pe_task_send_finish_flag
`ifdef MESH_ROUTE_ERR_EN
    ,
    output logic [NODES-1:0]     pe_route_error_flag
`endif
);
    flit_t [4:0] rt_in   [NODES];
    flit_t [4:0] rt_out  [NODES];
    logic  [4:0] rt_rdy  [NODES];
    logic  [4:0] out_rdy [NODES];

    for (genvar n = 0; n < NODES; n++) begin : g_node
        localparam int ROW = n / 4;
        localparam int COL = n % 4;

        mesh_pe #(.ID(n)) u_pe (
            .clk       (clk),
            .rst_n     (rst_n),
            .enable    (pe_enable[n]),
            .dbg_mode  (pe_dbg_mode_wire[n]),
            .flush     (pe_flush_wire[n]),
            .send_num  (pe_send_num_wire[IDW*n +: IDW]),
            .recv_num  (pe_receive_num_wire[IDW*n +: IDW]),
            .rate      (pe_rate_wire[4*n +: 4]),
            .mode      (pe_mode_wire[4*n +: 4]),
            .dst_seq   (pe_dst_seq_wire[24*n +: 24]),
            .inj_flit  (rt_in[n][0]),
            .inj_ready (rt_rdy[n][0]),
            .ej_flit   (rt_out[n][0]),
            .send_flag (pe_task_send_finish_flag[n]),
            .recv_flag (pe_task_receive_finish_flag[n])
`ifdef MESH_ROUTE_ERR_EN
            ,
            .route_err (pe_route_error_flag[n])
`endif
        );

        mesh_router #(.ID(n)) u_rt (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_flit   (rt_in[n]),
            .in_ready  (rt_rdy[n]),
            .out_flit  (rt_out[n]),
            .out_ready (out_rdy[n])
        );

        assign out_rdy[n][0] = 1'b1;

        // Mesh edges: tie off missing neighbours; XY routing never targets them.
        if (ROW == 1) begin : g_n
            assign rt_in[n][1]   = rt_out[n-4][2];
            assign out_rdy[n][1] = rt_rdy[n-4][2];
        end else begin : g_n_edge
            assign rt_in[n][1]   = '0;
            assign out_rdy[n][1] = 1'b0;
        end
        if (ROW == 0) begin : g_s
            assign rt_in[n][2]   = rt_out[n+4][1];
            assign out_rdy[n][2] = rt_rdy[n+4][1];
        end else begin : g_s_edge
            assign rt_in[n][2]   = '0;
            assign out_rdy[n][2] = 1'b0;
        end
        if (COL < 3) begin : g_e
            assign rt_in[n][3]   = rt_out[n+1][4];
            assign out_rdy[n][3] = rt_rdy[n+1][4];
        end else begin : g_e_edge
            assign rt_in[n][3]   = '0;
            assign out_rdy[n][3] = 1'b0;
        end
        if (COL > 0) begin : g_w
            assign rt_in[n][4]   = rt_out[n-1][3];
            assign out_rdy[n][4] = rt_rdy[n-1][3];
        end else begin : g_w_edge
            assign rt_in[n][4]   = '0;
            assign out_rdy[n][4] = 1'b0;
        end
    end
endmodule

// File: tb/tb_mesh_2x4_noc.sv
// Scoreboard bench for mesh_2x4_noc: stimulus queues expected flag states with latency windows,
// a monitor resolves them against the DUT flags on the falling clock edge.
module tb_mesh_2x4_noc;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   pe_enable;
    logic [7:0]   pe_dbg_mode_wire;
    logic [23:0]  pe_send_num_wire;
    logic [23:0]  pe_receive_num_wire;
    logic [31:0]  pe_rate_wire;
    logic [191:0] pe_dst_seq_wire;
    logic [31:0]  pe_mode_wire;
    logic [7:0]   pe_flush_wire;
    logic [7:0]   pe_task_receive_finish_flag;
    logic [7:0]   pe_task_send_finish_flag;
`ifdef MESH_ROUTE_ERR_EN
    logic [7:0]   pe_route_error_flag;
`endif

    always #5 clk = ~clk;

    mesh_2x4_noc dut (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .pe_enable                   (pe_enable),
        .pe_dbg_mode_wire            (pe_dbg_mode_wire),
        .pe_send_num_wire            (pe_send_num_wire),
        .pe_receive_num_wire         (pe_receive_num_wire),
        .pe_rate_wire                (pe_rate_wire),
        .pe_dst_seq_wire             (pe_dst_seq_wire),
        .pe_mode_wire                (pe_mode_wire),
        .pe_flush_wire               (pe_flush_wire),
        .pe_task_receive_finish_flag (pe_task_receive_finish_flag),
        .pe_task_send_finish_flag    (pe_task_send_finish_flag)
`ifdef MESH_ROUTE_ERR_EN
        ,
        .pe_route_error_flag         (pe_route_error_flag)
`endif
    );

    // kind 0: wait until (flags & mask) == exp, latency must land in [lo,hi]
    // kind 1: sample (flags & mask) exactly hi cycles after issue
    typedef struct {
        string       name;
        int          kind;
        logic [15:0] mask;
        logic [15:0] exp;
        int          lo;
        int          hi;
        int          start;
    } chk_t;

    chk_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    chk_t        c;
    int          el;
    logic [15:0] act;
    logic        busy;
    logic [2:0]  brev [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clk);
            busy = 1'b1;
            while (busy && q.size() != 0) begin
                c    = q[0];
                el   = cyc - c.start;
                act  = {pe_task_send_finish_flag, pe_task_receive_finish_flag} & c.mask;
                busy = 1'b0;
                if (c.kind == 0) begin
                    if (act == c.exp) begin
                        checks++;
                        if (el < c.lo || el > c.hi) begin
                            errors++;
                            $display("FAIL %s: latency %0d cycles, want %0d..%0d", c.name, el, c.lo, c.hi);
                        end
                        busy = 1'b1;
                    end else if (el >= c.hi) begin
                        checks++;
                        errors++;
                        $display("FAIL %s: timeout, flags %h want %h", c.name, act, c.exp);
                        busy = 1'b1;
                    end
                end else if (el >= c.hi) begin
                    checks++;
                    if (act != c.exp) begin
                        errors++;
                        $display("FAIL %s: flags %h want %h", c.name, act, c.exp);
                    end
                    busy = 1'b1;
                end
                if (busy) q.delete(0);
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic expect_flags(input string nm, input int kind, input logic [15:0] mask,
                                input logic [15:0] exp, input int lo, input int hi);
        chk_t e;
        e.name  = nm;
        e.kind  = kind;
        e.mask  = mask;
        e.exp   = exp;
        e.lo    = lo;
        e.hi    = hi;
        e.start = cyc;
        q.push_back(e);
    endtask

    task automatic drain();
        while (q.size() != 0) @(negedge clk);
        #1;
    endtask

    task automatic set_pe(input int i, input int snd, input int rcv, input int rt,
                          input int md, input logic [23:0] ds);
        pe_send_num_wire[3*i +: 3]    = 3'(snd);
        pe_receive_num_wire[3*i +: 3] = 3'(rcv);
        pe_rate_wire[4*i +: 4]        = 4'(rt);
        pe_mode_wire[4*i +: 4]        = 4'(md);
        pe_dst_seq_wire[24*i +: 24]   = ds;
    endtask

    task automatic flush_all();
        pe_enable     = 8'h00;
        pe_flush_wire = 8'hff;
        expect_flags("flush_clear", 1, 16'hffff, 16'h0000, 0, 1);
        step(6);
        pe_flush_wire = 8'h00;
        drain();
    endtask

    initial begin
        rst_n               = 1'b1;
        pe_enable           = '0;
        pe_dbg_mode_wire    = '0;
        pe_send_num_wire    = '0;
        pe_receive_num_wire = '0;
        pe_rate_wire        = '0;
        pe_dst_seq_wire     = '0;
        pe_mode_wire        = '0;
        pe_flush_wire       = '0;
        step(3);
        rst_n = 1'b0;
        expect_flags("reset_state", 1, 16'hffff, 16'h0000, 0, 2);
        drain();

        // Bit complement, with destination checking enabled
        flush_all();
        for (int i = 0; i < 8; i++) set_pe(i, 1, 1, 0, 1, {21'b0, 3'(7 - i)});
        pe_dbg_mode_wire = 8'hff;
        pe_enable        = 8'hff;
        expect_flags("bitcomp_all", 0, 16'hffff, 16'hffff, 0, 20);
        drain();
        pe_dbg_mode_wire = 8'h00;

        // Bit reverse: PE0 and PE7 deliver to themselves
        flush_all();
        for (int i = 0; i < 8; i++) set_pe(i, 1, 1, 0, 1, {21'b0, brev[i]});
        pe_enable = 8'hff;
        expect_flags("brev_pe0_send", 0, 16'h0100, 16'h0100, 2, 2);
        expect_flags("brev_pe0_self", 0, 16'h0001, 16'h0001, 3, 3);
        expect_flags("brev_pe7_self", 0, 16'h0080, 16'h0080, 3, 3);
        expect_flags("brev_all", 0, 16'hffff, 16'hffff, 0, 20);
        drain();

        // Hotspot: everyone sends one flit to node 0
        flush_all();
        set_pe(0, 0, 7, 0, 1, 24'h0);
        for (int i = 1; i < 8; i++) set_pe(i, 1, 0, 0, 1, 24'h0);
        pe_enable = 8'hff;
        expect_flags("hot_pe0_send0", 0, 16'h0100, 16'h0100, 1, 1);
        expect_flags("hot_pe1_recv0", 0, 16'h0002, 16'h0002, 0, 1);
        expect_flags("hot_pe0_recv7", 0, 16'h0001, 16'h0001, 10, 40);
        expect_flags("hot_all", 0, 16'hffff, 16'hffff, 0, 40);
        drain();

        // Rotate mode: each PE sends one flit to every other node
        flush_all();
        for (int i = 0; i < 8; i++) set_pe(i, 7, 7, 0, 0, 24'h0);
        pe_enable = 8'hff;
        expect_flags("turn_all", 0, 16'hffff, 16'hffff, 8, 300);
        drain();

        // Rate 3: PE0 sends two flits to node 3, four cycles apart
        flush_all();
        for (int i = 0; i < 8; i++) set_pe(i, 0, 0, 0, 1, 24'h0);
        set_pe(0, 2, 0, 3, 1, 24'o33);
        set_pe(3, 0, 2, 0, 1, 24'h0);
        pe_enable = 8'hff;
        expect_flags("rate_pe0_send", 0, 16'h0100, 16'h0100, 6, 6);
        expect_flags("rate_pe3_recv", 0, 16'h0008, 16'h0008, 10, 10);
        expect_flags("rate_all", 0, 16'hffff, 16'hffff, 0, 20);
        drain();

        // Flush PE0 right after its first injection; PE1 must see only one flit
        flush_all();
        for (int i = 0; i < 8; i++) set_pe(i, 0, 0, 0, 1, 24'h0);
        set_pe(0, 7, 0, 5, 1, 24'o11111111);
        set_pe(1, 0, 2, 0, 1, 24'h0);
        pe_enable = 8'h03;
        step(2);
        pe_flush_wire = 8'h01;
        expect_flags("flush_pe0_clear", 1, 16'h0101, 16'h0000, 0, 1);
        step(3);
        pe_enable     = 8'h00;
        pe_flush_wire = 8'h00;
        expect_flags("flush_no_inject", 1, 16'h0102, 16'h0000, 0, 30);
        drain();

        // Reset after all flags are up clears everything on the next edge
        flush_all();
        for (int i = 0; i < 8; i++) set_pe(i, 1, 1, 0, 1, {21'b0, 3'(7 - i)});
        pe_enable = 8'hff;
        expect_flags("pre_reset_all", 0, 16'hffff, 16'hffff, 0, 20);
        drain();
        rst_n = 1'b1;
        expect_flags("reset_mid", 1, 16'hffff, 16'h0000, 0, 1);
        step(2);
        pe_enable = 8'h00;
        rst_n     = 1'b0;
        drain();

`ifdef MESH_ROUTE_ERR_EN
        checks++;
        if (pe_route_error_flag != 8'h00) begin
            errors++;
            $display("FAIL route_err: flags %h want 00", pe_route_error_flag);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
